// File: rtl/stage_id_hazard.sv
// stage_id_hazard
//   MIPS instruction-decode stage sitting between IF/ID and ID/EX. Decodes the
//   incoming instruction, reads the internal register file (x0 hardwired to
//   zero), extends imm16 and registers everything into the ID/EX register.
//   Also tracks validity, detects load-use hazards (stall + bubble) and
//   squashes the entering instruction on flush.
//
// Optional feature macro: STAGE_ID_BYPASS_EN
//   defined   -> a writeback to rs/rt in the same cycle is forwarded into
//                reg1/reg2 (write-through register file).
//   undefined -> reg1/reg2 capture the old register-file contents.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   instr, instrValid   instruction from IF/ID and its valid flag
//   flush               squash the instruction entering ID/EX
//   writeData/Addr,
//   regWrite            writeback port of the register file
//   stall               combinational hold request to IF/ID
//   outValid            ID/EX holds a real instruction
//   aluOp .. regDst,
//   wbi                 registered decode controls
//   reg1, reg2          registered rs / rt read values
//   extendedInstr       registered extended imm16
//   regAddr1, regAddr2  registered rd / rt addresses
module stage_id_hazard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instrValid,
  input  logic              flush,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic              regWrite,
  output logic              stall,
  output logic              outValid,
  output logic [3:0]        aluOp,
  output logic              isJump,
  output logic              isNotConditional,
  output logic              isEq,
  output logic              memWrite,
  output logic              memRead,
  output logic              aluSrc,
  output logic              regDst,
  output logic [1:0]        wbi,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] extendedInstr,
  output logic [ADDR_W-1:0] regAddr1,
  output logic [ADDR_W-1:0] regAddr2
);

  localparam int NREG = 2 ** ADDR_W;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       is_jump;
    logic       is_not_cond;
    logic       is_eq;
    logic       mem_write;
    logic [1:0] wbi;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] extend_imm(input logic [15:0] imm,
                                                    input logic       zero_ext);
    logic signed [DATA_W-1:0] sext;
    sext = DATA_W'(signed'(imm));
    return zero_ext ? DATA_W'(imm) : sext;
  endfunction

  // Instruction fields (low ADDR_W bits of each register field)
  logic [5:0]        op;
  logic [ADDR_W-1:0] rs, rt, rd;
  assign op = instr[31:26];
  assign rs = instr[21 +: ADDR_W];
  assign rt = instr[16 +: ADDR_W];
  assign rd = instr[11 +: ADDR_W];

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  ctrl_t             ctrl_q, ctrl_d, dec;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d, ext_q, ext_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [DATA_W-1:0] rd1, rd2;
  logic              zero_ext, uses_rt, stall_raw;

  // Decode
  always_comb begin
    dec      = '0;
    zero_ext = 1'b0;
    uses_rt  = 1'b1;
    unique case (op)
      OP_R:    dec = '{alu_op: 4'd2, wbi: 2'b11, reg_dst: 1'b1, default: '0};
      OP_J: begin
        dec     = '{alu_op: 4'd1, is_jump: 1'b1, is_not_cond: 1'b1, default: '0};
        uses_rt = 1'b0;
      end
      OP_BEQ:  dec = '{alu_op: 4'd1, is_jump: 1'b1, is_eq: 1'b1, default: '0};
      OP_BNE:  dec = '{alu_op: 4'd1, is_jump: 1'b1, default: '0};
      OP_ADDI: begin
        dec     = '{alu_op: 4'd8, wbi: 2'b11, alu_src: 1'b1, default: '0};
        uses_rt = 1'b0;
      end
      OP_ANDI, OP_ORI: begin
        dec      = '{alu_op: {3'b110, op[0]}, wbi: 2'b11, alu_src: 1'b1, default: '0};
        zero_ext = 1'b1;
        uses_rt  = 1'b0;
      end
      OP_LB, OP_LH, OP_LW: begin
        dec     = '{wbi: 2'b01, mem_read: 1'b1, alu_src: 1'b1, default: '0};
        uses_rt = 1'b0;
      end
      OP_SB, OP_SH, OP_SW: dec = '{mem_write: 1'b1, alu_src: 1'b1, default: '0};
      default: dec = '0;
    endcase
  end

  // Register-file read; x0 forced to zero regardless of contents
  always_comb begin
    rd1 = rf_q[rs];
    rd2 = rf_q[rt];
`ifdef STAGE_ID_BYPASS_EN
    if (regWrite && writeAddr != '0 && writeAddr == rs) rd1 = writeData;
    if (regWrite && writeAddr != '0 && writeAddr == rt) rd2 = writeData;
`endif
    if (rs == '0) rd1 = '0;
    if (rt == '0) rd2 = '0;
  end

  always_comb begin
    rf_d = rf_q;
    if (regWrite && writeAddr != '0) rf_d[writeAddr] = writeData;
  end

  // Load in EX whose destination (rt) is a source of the instruction in ID.
  // Flush and reset both win over the hold request.
  assign stall_raw = instrValid & valid_q & ctrl_q.mem_read & (addr2_q != '0) &
                     ((addr2_q == rs) | ((addr2_q == rt) & uses_rt));
  assign stall     = stall_raw & ~flush & ~reset;

  // Bubbles clear valid and controls but leave the data registers alone
  always_comb begin
    ctrl_d  = '0;
    valid_d = 1'b0;
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    ext_d   = ext_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    if (!flush && !stall_raw && instrValid) begin
      ctrl_d  = dec;
      valid_d = 1'b1;
      reg1_d  = rd1;
      reg2_d  = rd2;
      ext_d   = extend_imm(instr[15:0], zero_ext);
      addr1_d = rd;
      addr2_d = rt;
    end
  end

  // ID/EX register boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      reg1_q  <= '0;
      reg2_q  <= '0;
      ext_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
    end else begin
      rf_q    <= rf_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      ext_q   <= ext_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
    end
  end

  assign outValid         = valid_q;
  assign aluOp            = ctrl_q.alu_op;
  assign isJump           = ctrl_q.is_jump;
  assign isNotConditional = ctrl_q.is_not_cond;
  assign isEq             = ctrl_q.is_eq;
  assign memWrite         = ctrl_q.mem_write;
  assign memRead          = ctrl_q.mem_read;
  assign aluSrc           = ctrl_q.alu_src;
  assign regDst           = ctrl_q.reg_dst;
  assign wbi              = ctrl_q.wbi;
  assign reg1             = reg1_q;
  assign reg2             = reg2_q;
  assign extendedInstr    = ext_q;
  assign regAddr1         = addr1_q;
  assign regAddr2         = addr2_q;

endmodule

// File: tb/tb_stage_id_hazard.sv
module tb_stage_id_hazard;

  logic        clock = 1'b0;
  logic        reset, instrValid, flush, regWrite;
  logic [31:0] instr, writeData;
  logic [4:0]  writeAddr;
  logic        stall, outValid, isJump, isNotConditional, isEq;
  logic        memWrite, memRead, aluSrc, regDst;
  logic [3:0]  aluOp;
  logic [1:0]  wbi;
  logic [31:0] reg1, reg2, extendedInstr;
  logic [4:0]  regAddr1, regAddr2;
  logic [12:0] ctrl;

  int errors = 0;
  int checks = 0;

  stage_id_hazard #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .instr(instr), .instrValid(instrValid),
    .flush(flush), .writeData(writeData), .writeAddr(writeAddr),
    .regWrite(regWrite), .stall(stall), .outValid(outValid), .aluOp(aluOp),
    .isJump(isJump), .isNotConditional(isNotConditional), .isEq(isEq),
    .memWrite(memWrite), .memRead(memRead), .aluSrc(aluSrc), .regDst(regDst),
    .wbi(wbi), .reg1(reg1), .reg2(reg2), .extendedInstr(extendedInstr),
    .regAddr1(regAddr1), .regAddr2(regAddr2)
  );

  always #5 clock = ~clock;

  // {aluOp, isJump, isNotConditional, isEq, memWrite, wbi, memRead, aluSrc, regDst}
  assign ctrl = {aluOp, isJump, isNotConditional, isEq, memWrite, wbi, memRead, aluSrc, regDst};

  localparam logic [12:0] C_NOP  = 13'b0000_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_R    = 13'b0010_0_0_0_0_11_0_0_1;
  localparam logic [12:0] C_ANDI = 13'b1100_0_0_0_0_11_0_1_0;
  localparam logic [12:0] C_ORI  = 13'b1101_0_0_0_0_11_0_1_0;
  localparam logic [12:0] C_ADDI = 13'b1000_0_0_0_0_11_0_1_0;
  localparam logic [12:0] C_LD   = 13'b0000_0_0_0_0_01_1_1_0;
  localparam logic [12:0] C_ST   = 13'b0000_0_0_0_1_00_0_1_0;
  localparam logic [12:0] C_BEQ  = 13'b0001_1_0_1_0_00_0_0_0;
  localparam logic [12:0] C_BNE  = 13'b0001_1_0_0_0_00_0_0_0;
  localparam logic [12:0] C_J    = 13'b0001_1_1_0_0_00_0_0_0;

  localparam logic [31:0] I_ANDI = 32'h30220820; // rs1 rt2 rd1 imm 0x0820
  localparam logic [31:0] I_LH   = 32'h84220020; // rs1 rt2
  localparam logic [31:0] I_LW   = 32'h8C220000; // rs1 rt2
  localparam logic [31:0] I_ADD  = 32'h00432020; // rs2 rt3 rd4
  localparam logic [31:0] I_ADDI = 32'h20228001; // rs1 rt2 imm 0x8001
  localparam logic [31:0] I_ORI  = 32'h34228001; // rs1 rt2 rd16 imm 0x8001
  localparam logic [31:0] I_SW   = 32'hAC220004; // rs1 rt2
  localparam logic [31:0] I_BEQ  = 32'h10210003; // rs1 rt1 imm 3
  localparam logic [31:0] I_BNE  = 32'h1422FFFF; // rs1 rt2 imm -1
  localparam logic [31:0] I_J    = 32'h096C0020;
  localparam logic [31:0] I_BAD  = 32'hFC000000; // opcode 0x3F
  localparam logic [31:0] I_RS3  = 32'h00600000; // R-type rs3 rt0
  localparam logic [31:0] I_RS0  = 32'h00000000; // R-type rs0 rt0

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    regWrite = 1'b1; writeAddr = a; writeData = d; instrValid = 1'b0;
    tick();
    regWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick();
    reset = 1'b0;
    wb(5'd7, 32'd77);
    reset = 1'b1;
    instr = I_LW; instrValid = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    tick();
    reset = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", outValid); end
    checks++; if (ctrl !== C_NOP) begin errors++; $display("FAIL reset_ctrl got %h want %h", ctrl, C_NOP); end
    checks++; if ({reg1, reg2, extendedInstr} !== 96'd0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", reg1, reg2, extendedInstr); end
    checks++; if ({regAddr1, regAddr2} !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d %0d want 0", regAddr1, regAddr2); end
    for (int i = 1; i < 32; i++) begin
      instr = {6'd0, 5'(i), 5'(i), 16'h0}; instrValid = 1'b1;
      tick();
      checks++; if ({reg1, reg2} !== 64'd0) begin errors++; $display("FAIL reset_rf x%0d got %h %h want 0", i, reg1, reg2); end
    end
    checks++; if (ctrl !== C_R || outValid !== 1'b1) begin errors++; $display("FAIL r_decode got %h/%0b want %h/1", ctrl, outValid, C_R); end
  endtask

  task automatic test_andi();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd6);
    instr = I_ANDI; instrValid = 1'b1;
    tick();
    checks++; if (ctrl !== C_ANDI) begin errors++; $display("FAIL andi_ctrl got %h want %h", ctrl, C_ANDI); end
    checks++; if (reg1 !== 32'd5 || reg2 !== 32'd6) begin errors++; $display("FAIL andi_regs got %0d %0d want 5 6", reg1, reg2); end
    checks++; if (regAddr1 !== 5'd1 || regAddr2 !== 5'd2) begin errors++; $display("FAIL andi_addr got %0d %0d want 1 2", regAddr1, regAddr2); end
    checks++; if (extendedInstr !== 32'h0000_0820) begin errors++; $display("FAIL andi_ext got %h want 00000820", extendedInstr); end
  endtask

  task automatic test_load_use();
    instr = I_LH; instrValid = 1'b1;
    tick();
    checks++; if (ctrl !== C_LD || outValid !== 1'b1) begin errors++; $display("FAIL lh_ctrl got %h/%0b want %h/1", ctrl, outValid, C_LD); end
    instr = I_ADD;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall); end
    tick();
    checks++; if (outValid !== 1'b0 || ctrl !== C_NOP) begin errors++; $display("FAIL lu_bubble got %0b/%h want 0/%h", outValid, ctrl, C_NOP); end
    checks++; if (reg1 !== 32'd5 || regAddr2 !== 5'd2) begin errors++; $display("FAIL lu_hold got %0d %0d want 5 2", reg1, regAddr2); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0b want 0", stall); end
    tick();
    checks++; if (outValid !== 1'b1 || ctrl !== C_R) begin errors++; $display("FAIL lu_issue got %0b/%h want 1/%h", outValid, ctrl, C_R); end
    checks++; if (reg1 !== 32'd6 || regAddr1 !== 5'd4 || regAddr2 !== 5'd3) begin errors++; $display("FAIL lu_issue_data got %0d %0d %0d want 6 4 3", reg1, regAddr1, regAddr2); end
    // store reads rt: hazard on rt
    instr = I_LW; tick();
    instr = I_SW; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_rt_stall got %0b want 1", stall); end
    tick(); tick();
    checks++; if (ctrl !== C_ST || outValid !== 1'b1) begin errors++; $display("FAIL sw_issue got %h/%0b want %h/1", ctrl, outValid, C_ST); end
    // ADDI writes rt: no hazard on rt, and an invalid instr never stalls
    instr = I_LW; tick();
    instr = I_ADD; instrValid = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_invalid got %0b want 0", stall); end
    instr = I_ADDI; instrValid = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_addi got %0b want 0", stall); end
    tick();
    checks++; if (ctrl !== C_ADDI || extendedInstr !== 32'hFFFF_8001) begin errors++; $display("FAIL addi got %h/%h want %h/ffff8001", ctrl, extendedInstr, C_ADDI); end
  endtask

  task automatic test_flush_stall();
    instr = I_LH; instrValid = 1'b1; tick();
    instr = I_ADD; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_pre got %0b want 1", stall); end
    flush = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %0b want 0", stall); end
    tick();
    flush = 1'b0;
    checks++; if (outValid !== 1'b0 || ctrl !== C_NOP) begin errors++; $display("FAIL fl_bubble got %0b/%h want 0/%h", outValid, ctrl, C_NOP); end
    instr = I_ORI; tick();
    checks++; if (ctrl !== C_ORI || regAddr1 !== 5'd16 || outValid !== 1'b1) begin errors++; $display("FAIL fl_next got %h/%0d/%0b want %h/16/1", ctrl, regAddr1, outValid, C_ORI); end
    checks++; if (extendedInstr !== 32'h0000_8001 || reg1 !== 32'd5) begin errors++; $display("FAIL ori_ext got %h/%0d want 00008001/5", extendedInstr, reg1); end
  endtask

  task automatic test_branch_jump();
    instr = I_BEQ; instrValid = 1'b1; tick();
    checks++; if (ctrl !== C_BEQ) begin errors++; $display("FAIL beq_ctrl got %h want %h", ctrl, C_BEQ); end
    checks++; if (reg1 !== 32'd5 || reg2 !== 32'd5) begin errors++; $display("FAIL beq_regs got %0d %0d want 5 5", reg1, reg2); end
    instr = I_BNE; tick();
    checks++; if (ctrl !== C_BNE || extendedInstr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bne got %h/%h want %h/ffffffff", ctrl, extendedInstr, C_BNE); end
    instr = I_J; tick();
    checks++; if (ctrl !== C_J || outValid !== 1'b1) begin errors++; $display("FAIL j_ctrl got %h/%0b want %h/1", ctrl, outValid, C_J); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (ctrl !== C_NOP || outValid !== 1'b0) begin errors++; $display("FAIL j_flush got %h/%0b want %h/0", ctrl, outValid, C_NOP); end
    instr = I_BAD; tick();
    checks++; if (ctrl !== C_NOP || outValid !== 1'b1) begin errors++; $display("FAIL unknown_op got %h/%0b want %h/1", ctrl, outValid, C_NOP); end
    instr = I_ADDI; instrValid = 1'b0; tick();
    checks++; if (ctrl !== C_NOP || outValid !== 1'b0) begin errors++; $display("FAIL invalid got %h/%0b want %h/0", ctrl, outValid, C_NOP); end
  endtask

  task automatic test_writeback_bypass();
    logic [31:0] exp_byp;
`ifdef STAGE_ID_BYPASS_EN
    exp_byp = 32'd40;
`else
    exp_byp = 32'd0;
`endif
    regWrite = 1'b1; writeAddr = 5'd3; writeData = 32'd40;
    instr = I_RS3; instrValid = 1'b1; tick();
    regWrite = 1'b0;
    checks++; if (reg1 !== exp_byp) begin errors++; $display("FAIL wb_same_cycle got %0d want %0d", reg1, exp_byp); end
    tick();
    checks++; if (reg1 !== 32'd40) begin errors++; $display("FAIL wb_after got %0d want 40", reg1); end
    regWrite = 1'b1; writeAddr = 5'd0; writeData = 32'd9;
    instr = I_RS0; tick();
    regWrite = 1'b0;
    checks++; if (reg1 !== 32'd0 || reg2 !== 32'd0) begin errors++; $display("FAIL x0_same got %0d %0d want 0 0", reg1, reg2); end
    tick();
    checks++; if (reg1 !== 32'd0 || reg2 !== 32'd0) begin errors++; $display("FAIL x0_after got %0d %0d want 0 0", reg1, reg2); end
  endtask

  task automatic test_reset_mid_stall();
    instr = I_LH; instrValid = 1'b1; tick();
    instr = I_ADD; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre got %0b want 1", stall); end
    reset = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_stall got %0b want 0", stall); end
    tick();
    reset = 1'b0;
    checks++; if (outValid !== 1'b0 || ctrl !== C_NOP || regAddr2 !== 5'd0) begin errors++; $display("FAIL rms_state got %0b/%h/%0d want 0/%h/0", outValid, ctrl, regAddr2, C_NOP); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_after got %0b want 0", stall); end
    tick();
    checks++; if (outValid !== 1'b1 || reg1 !== 32'd0) begin errors++; $display("FAIL rms_rf got %0b/%0d want 1/0", outValid, reg1); end
  endtask

  initial begin
    reset = 1'b1; instr = '0; instrValid = 1'b0; flush = 1'b0;
    regWrite = 1'b0; writeAddr = '0; writeData = '0;
    test_reset();
    test_andi();
    test_load_use();
    test_flush_stall();
    test_branch_jump();
    test_writeback_bypass();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
